// File: rtl/gcd_arb_pkg.sv
`default_nettype none
// ============================================================================
// gcd_arb_pkg : FSM state type and default sizing shared by gcd_req_arbiter
// Revision    : 1.0
// ============================================================================
package gcd_arb_pkg;

  localparam int c_nreq_default = 4;
  localparam int c_w_default    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// gcd_req_arbiter_if : requester-side request/response bundle of gcd_req_arbiter
// Revision           : 1.0
// ============================================================================
interface gcd_req_arbiter_if
  import gcd_arb_pkg::*;
#(
  parameter int NREQ = c_nreq_default,
  parameter int W    = c_w_default
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*W-1:0]       req_a;
  logic [NREQ*W-1:0]       req_b;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic [W-1:0]            rsp_gcd;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_gcd, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_gcd, rsp_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/gcd_core.sv
`default_nettype none
// ============================================================================
// gcd_core : subtractive GCD engine; done is high once either operand is zero
// Revision : 1.0
// ============================================================================
module gcd_core
  import gcd_arb_pkg::*;
#(
  parameter int W = c_w_default
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         done,
  output logic [W-1:0] result
);

  logic [W-1:0] r_x;
  logic [W-1:0] r_y;

  // Stepping stops by itself once an operand reaches zero, so no enable is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (start) begin
      r_x <= x_in;
      r_y <= y_in;
    end else if ((r_x != '0) && (r_y != '0)) begin
      if (r_x > r_y) begin
        r_x <= r_x - r_y;
      end else begin
        r_y <= r_y - r_x;
      end
    end
  end

  assign done   = (r_x == '0) || (r_y == '0);
  assign result = (r_x == '0) ? r_y : r_x;

endmodule
`default_nettype wire

// File: rtl/gcd_req_arbiter.sv
`default_nettype none
// ============================================================================
// gcd_req_arbiter : round-robin arbiter sharing one GCD engine between NREQ
//                   requesters; GCD_ARB_ZERO_BYPASS_EN skips COMPUTE on zero
//                   operands. Revision 1.0
// ============================================================================
module gcd_req_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NREQ = c_nreq_default,
  parameter int W    = c_w_default
) (
  input  logic             clk,
  input  logic             rst,
  gcd_req_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NREQ);

  state_t          r_state;
  state_t          w_next_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_scan;
  logic            w_any;
  logic            w_start;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [W-1:0]    r_rsp_gcd;
  logic            w_core_done;
  logic [W-1:0]    w_core_result;
`ifdef GCD_ARB_ZERO_BYPASS_EN
  logic            w_zero_op;
`endif

  // First pending requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_scan   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = ID_W'((int'(r_ptr) + k) % NREQ);
      if (!w_any && bus.req_valid[w_scan]) begin
        w_any    = 1'b1;
        w_winner = w_scan;
      end
    end
  end

  assign w_start = !rst && (r_state == ST_IDLE) && w_any;
  assign w_a     = bus.req_a[int'(w_winner)*W +: W];
  assign w_b     = bus.req_b[int'(w_winner)*W +: W];
`ifdef GCD_ARB_ZERO_BYPASS_EN
  assign w_zero_op = (w_a == '0) || (w_b == '0);
`endif

  gcd_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .x_in   (w_a),
    .y_in   (w_b),
    .done   (w_core_done),
    .result (w_core_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
`ifdef GCD_ARB_ZERO_BYPASS_EN
          w_next_state = w_zero_op ? ST_RESP : ST_COMPUTE;
`else
          w_next_state = ST_COMPUTE;
`endif
        end
      end
      ST_COMPUTE: begin
        if (w_core_done) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_start) begin
      bus.req_ready[w_winner] = 1'b1;
    end
    bus.busy      = (r_state != ST_IDLE);
    bus.rsp_valid = (r_state == ST_RESP);
    bus.rsp_gcd   = r_rsp_gcd;
    bus.rsp_id    = r_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_rsp_gcd <= '0;
    end else begin
      if (w_start) begin
        r_id  <= w_winner;
        r_ptr <= (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
`ifdef GCD_ARB_ZERO_BYPASS_EN
        if (w_zero_op) begin
          r_rsp_gcd <= w_a | w_b;
        end
`endif
      end
      if ((r_state == ST_COMPUTE) && w_core_done) begin
        r_rsp_gcd <= w_core_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_gcd_req_arbiter : scoreboard bench for gcd_req_arbiter (either build of
//                      GCD_ARB_ZERO_BYPASS_EN). Revision 1.0
// ============================================================================
module tb_gcd_req_arbiter;

  localparam int N      = 4;
  localparam int WD     = 8;
  localparam int BUDGET = 8000;

  typedef struct {
    int cyc;
    int id;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t grant_q[$];
  exp_t rsp_q[$];

  // Reference model state
  int m_ptr;
  int m_busy_until;
  int m_acc_cyc;
  int acc_id;
  bit pend    [N];
  int opa     [N];
  int opb     [N];
  int rsp_cyc [N];
  int plan_a  [N][16];
  int plan_b  [N][16];
  int plan_n  [N];
  int plan_i  [N];

  gcd_req_arbiter_if #(.NREQ(N), .W(WD)) bus ();

  gcd_req_arbiter #(.NREQ(N), .W(WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtraction count equals the sum of Euclid quotients; plus one final COMPUTE and RESP.
  function automatic int latency(int a, int b);
    int s;
    int t;
    s = 0;
    if (a == 0 || b == 0) begin
`ifdef GCD_ARB_ZERO_BYPASS_EN
      return 1;
`else
      return 2;
`endif
    end
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return s + 2;
  endfunction

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic add_op(int i, int a, int b);
    plan_a[i][plan_n[i]] = a;
    plan_b[i][plan_n[i]] = b;
    plan_n[i]++;
  endtask

  function automatic bit all_idle();
    bit r;
    r = (grant_q.size() == 0) && (rsp_q.size() == 0);
    for (int i = 0; i < N; i++) begin
      if (pend[i] || plan_i[i] < plan_n[i]) r = 1'b0;
    end
    return r;
  endfunction

  task automatic load_and_drive();
    logic [N-1:0]    v;
    logic [N*WD-1:0] va;
    logic [N*WD-1:0] vb;
    if (acc_id >= 0) begin
      pend[acc_id] = 1'b0;
      acc_id = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && plan_i[i] < plan_n[i] && cyc > rsp_cyc[i]) begin
        pend[i] = 1'b1;
        opa[i]  = plan_a[i][plan_i[i]];
        opb[i]  = plan_b[i][plan_i[i]];
        plan_i[i]++;
      end
    end
    v  = '0;
    va = '0;
    vb = '0;
    for (int i = 0; i < N; i++) begin
      v[i]           = pend[i];
      va[i*WD +: WD] = WD'(opa[i]);
      vb[i*WD +: WD] = WD'(opb[i]);
    end
    bus.req_valid = v;
    bus.req_a     = va;
    bus.req_b     = vb;
  endtask

  task automatic arbitrate();
    int w;
    int lat;
    w = -1;
    if (!rst && cyc >= m_busy_until) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w >= 0) begin
        lat = latency(opa[w], opb[w]);
        grant_q.push_back('{cyc, w, 0});
        rsp_q.push_back('{cyc + lat, w, ref_gcd(opa[w], opb[w])});
        m_acc_cyc    = cyc;
        m_busy_until = cyc + lat + 1;
        m_ptr        = (w + 1) % N;
        acc_id       = w;
        rsp_cyc[w]   = cyc + lat;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    load_and_drive();
    arbitrate();
  endtask

  // Any operation in flight is abandoned; pending requesters keep requesting.
  task automatic do_reset();
    rst = 1'b1;
    if (acc_id >= 0) pend[acc_id] = 1'b0;
    acc_id       = -1;
    m_ptr        = 0;
    m_busy_until = 0;
    m_acc_cyc    = -1;
    grant_q.delete();
    rsp_q.delete();
    for (int i = 0; i < N; i++) rsp_cyc[i] = -1;
    load_and_drive();
    #1;
    check("busy_on_reset", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    check("req_ready_in_reset", int'(bus.req_ready), 0);
    check("rsp_valid_in_reset", int'(bus.rsp_valid), 0);
    check("rsp_gcd_in_reset", int'(bus.rsp_gcd), 0);
    check("rsp_id_in_reset", int'(bus.rsp_id), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_and_drive();
    arbitrate();
  endtask

  task automatic run_phase(string name);
    int n;
    n = 0;
    while (!all_idle() && n < BUDGET) begin
      step();
      n++;
    end
    if (!all_idle()) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: %0d grants and %0d responses outstanding", name,
               grant_q.size(), rsp_q.size());
      grant_q.delete();
      rsp_q.delete();
      for (int i = 0; i < N; i++) begin
        pend[i]   = 1'b0;
        plan_i[i] = plan_n[i];
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT grants or responds.
  always @(negedge clk) begin
    exp_t e;
    if (grant_q.size() > 0 && grant_q[0].cyc < cyc) begin
      e = grant_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_grant: requester %0d expected at cycle %0d, did not occur", e.id, e.cyc);
    end
    if (bus.req_ready != '0) begin
      if (grant_q.size() == 0) begin
        check("unexpected_grant", int'(bus.req_ready), 0);
      end else begin
        e = grant_q.pop_front();
        check("grant_cycle", cyc, e.cyc);
        check("grant_onehot", int'(bus.req_ready), 1 << e.id);
      end
    end
    if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
      e = rsp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_response: id %0d expected at cycle %0d, did not occur", e.id, e.cyc);
    end
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp_valid", int'(bus.rsp_valid), 0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_cycle", cyc, e.cyc);
        check("rsp_gcd", int'(bus.rsp_gcd), e.val);
        check("rsp_id", int'(bus.rsp_id), e.id);
      end
    end
    check("busy", int'(bus.busy), (cyc > m_acc_cyc && cyc < m_busy_until) ? 1 : 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    m_ptr        = 0;
    m_busy_until = 0;
    m_acc_cyc    = -1;
    acc_id       = -1;
    for (int i = 0; i < N; i++) begin
      pend[i]    = 1'b0;
      opa[i]     = 0;
      opb[i]     = 0;
      rsp_cyc[i] = -1;
      plan_n[i]  = 0;
      plan_i[i]  = 0;
    end
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    #2;

    // All four requesters pending through reset, then released together.
    add_op(0, 48, 18);
    add_op(1, 7, 5);
    add_op(2, 100, 75);
    add_op(3, 9, 9);
    do_reset();
    run_phase("all_four");

    // Lone requester 2 with (12,8).
    add_op(2, 12, 8);
    do_reset();
    run_phase("single");

    // Requesters 0 and 3 requesting continuously from reset.
    for (int k = 0; k < 4; k++) begin
      add_op(0, $urandom_range(1, 60), $urandom_range(1, 60));
      add_op(3, $urandom_range(1, 60), $urandom_range(1, 60));
    end
    do_reset();
    run_phase("fairness");

    // Zero operands.
    add_op(0, 0, 0);
    add_op(1, 0, 15);
    add_op(2, 21, 0);
    run_phase("zero_ops");

    // Reset during a long COMPUTE with requester 1 waiting.
    add_op(0, 255, 1);
    do_reset();
    repeat (3) step();
    add_op(1, 30, 12);
    repeat (3) step();
    do_reset();
    run_phase("reset_mid_compute");

    // Randomized traffic with a share of zero operands.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) begin
        a = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255);
        b = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255);
        add_op(i, a, b);
      end
    end
    run_phase("random");

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gcd_req_arbiter.md
GCD_REQ_ARBITER -- requirements
Module: gcd_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, operand and result width in bits.
REQ-003 SHALL have `clk  input  1`, the clock; all state updates on its rising edge.
REQ-004 SHALL have `rst  input  1`, the reset: asynchronous, active-high.
REQ-005 SHALL have `req_valid  input  NREQ`, per-requester operation request.
REQ-006 SHALL have `req_a  input  NREQ*W`, operand A; requester i on bits [i*W +: W].
REQ-007 SHALL have `req_b  input  NREQ*W`, operand B; same packing as req_a.
REQ-008 SHALL have `req_ready  output  NREQ`, one-hot acceptance strobe, combinational.
REQ-009 SHALL have `rsp_valid  output  1`, one-cycle result strobe.
REQ-010 SHALL have `rsp_gcd  output  W`, the GCD result, valid only with rsp_valid.
REQ-011 SHALL have `rsp_id  output  $clog2(NREQ)`, index of the requester owning rsp_gcd.
REQ-012 SHALL have `busy  output  1`, high whenever state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, COMPUTE and RESP.
REQ-014 Winner selection SHALL occur in IDLE with any req_valid bit set.
- Winner is the first set req_valid index at or above pointer p, searching modulo NREQ.
- req_ready[winner] is high in that same cycle; all other req_ready bits are low.
REQ-015 On the accepting edge the block SHALL perform all of the following.
- Latch x=req_a[winner], y=req_b[winner], and id=winner.
- Set p=(winner+1) mod NREQ.
- Go to COMPUTE.
REQ-016 In COMPUTE and RESP, req_ready SHALL be all-zero and req_valid SHALL be ignored.
REQ-017 Each COMPUTE cycle SHALL take the first matching action below.
- x==0: result=y, go to RESP.
- y==0: result=x, go to RESP.
- x>y: x<=x-y.
- Otherwise: y<=y-x.
REQ-018 RESP SHALL last exactly one cycle and then return to IDLE.
- rsp_valid=1, rsp_gcd=result, rsp_id=id during that cycle.
REQ-019 gcd(0,0) SHALL be 0, and gcd(0,n)=gcd(n,0)=n; the block SHALL never hang on zero operands.
REQ-020 Latency for nonzero operands SHALL be as follows.
- rsp_valid is asserted in the cycle after the terminating COMPUTE cycle.
- Example (12,8): accept at edge 0; COMPUTE occupies cycles 1-4; RESP in cycle 5.
REQ-021 Requesters SHALL hold req_valid and operands stable until req_ready.
- A requester may re-request in the cycle after its own rsp_valid.
REQ-022 All arithmetic SHALL be unsigned W-bit.
- Subtraction never underflows, since only the larger or equal operand is reduced.
REQ-023 The back-to-back minimum SHALL be met: IDLE accepts a new request in the cycle immediately after RESP.

Reset
REQ-024 On reset the block SHALL hold: state=IDLE, p=0, rsp_valid=0, rsp_gcd=0, rsp_id=0, busy=0, req_ready=0.
REQ-025 Reset mid-operation SHALL abandon the operation with no response emitted.
- Requests still pending are re-arbitrated from p=0 after reset.

Configuration
REQ-026 Macro GCD_ARB_ZERO_BYPASS_EN defined: an accepted request with either operand zero SHALL go directly from IDLE to RESP.
- result=a|b; rsp_valid appears in the cycle after acceptance.
REQ-027 Macro GCD_ARB_ZERO_BYPASS_EN undefined: zero-operand requests SHALL traverse one COMPUTE cycle.
- rsp_valid appears two cycles after acceptance.
- Results are identical with and without the macro.

Structure
REQ-028 Package gcd_arb_pkg SHALL hold the FSM state enum and default NREQ/W constants.
REQ-029 The subtractive engine SHALL be sub-module gcd_core.
- Ports: clk, rst, start, x_in, y_in, done, result.
- The arbiter top holds the pointer, grant logic and response registers.

Verification
REQ-030 Single request: requester 2 requests (12,8) -> req_ready[2] in cycle 0; rsp_valid in cycle 5 with rsp_gcd=4, rsp_id=2.
REQ-031 All four request (48,18),(7,5),(100,75),(9,9) in the same cycle -> grant order 0,1,2,3; results 6,1,25,9; each rsp_id matches.
REQ-032 Fairness: requesters 0 and 3 request continuously from reset -> grants alternate 0,3,0,3; neither is granted twice in a row.
REQ-033 Zero operands (0,0),(0,15),(21,0) -> results 0,15,21; no hang; rsp_valid latency matches REQ-026/027 for the build under test.
REQ-034 Reset mid-COMPUTE on (255,1) -> no rsp_valid, busy=0 immediately; pending request 1 is granted first after reset release (p=0, req 0 idle).
